// File: rtl/phy_types_pkg.sv
// Shared types and default sizing for the comma/data arbitration buffer.
package phy_types_pkg;

  typedef enum logic [1:0] {
    IDLE_SEL         = 2'd0,
    ACK_SEL          = 2'd1,
    GRTCRED_SEL      = 2'd2,
    START_PACKET_SEL = 2'd3
  } comma_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COMMA = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_t;

  localparam int DEFAULT_NUM_VC    = 2;
  localparam int DEFAULT_CNT_W     = 4;
  localparam int DEFAULT_ACK_DEPTH = 4;
  localparam int HEADER_W          = 8;

endpackage

// File: rtl/sync_header_fifo.sv
// Small synchronous FIFO holding ack headers; head is visible without a pop.
module sync_header_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == OCC_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset because occupancy guards every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + OCC_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - OCC_W'(1);
      end
    end
  end

endmodule

// File: rtl/multi_vc_arb_buffer.sv
// Arbitrates ack commas, per-VC credit-grant commas and data packet starts
// towards the encoder, one transmission at a time.
module multi_vc_arb_buffer
  import phy_types_pkg::*;
#(
  parameter int NUM_VC    = DEFAULT_NUM_VC,
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter int ACK_DEPTH = DEFAULT_ACK_DEPTH
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ack_write,
  input  logic [7:0]        rx_header,
  input  logic [NUM_VC-1:0] grtcred_write,
  input  logic              data_write,
  input  logic              done,
  input  logic              packet_done,
  output logic              start,
  output comma_sel_t        comma_sel,
  output logic [7:0]        comma_header_out,
  output logic              get_data,
  output logic              ack_cnt_full,
  output logic [NUM_VC-1:0] grtcred_full,
  output logic              send_data_cnt_full,
  output logic              busy
);

  localparam int VC_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  arb_state_t        state;
  logic [VC_W-1:0]   rr_ptr;
  logic [VC_W-1:0]   grant_idx;
  logic              cred_found;
  logic [NUM_VC-1:0] cred_nz;
  logic [NUM_VC-1:0] cred_dec;
  logic [CNT_W-1:0]  data_cnt;
  logic [7:0]        fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              sel_ack;
  logic              sel_cred;
  logic              sel_data;

  sync_header_fifo #(
    .DEPTH (ACK_DEPTH),
    .WIDTH (HEADER_W)
  ) u_ack_fifo (
    .clk   (CLK),
    .rst_n (nRST),
    .push  (ack_write),
    .pop   (sel_ack),
    .wdata (rx_header),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ack_cnt_full = fifo_full;
  assign busy         = (state != ST_IDLE);

  // Round-robin search for the first VC with pending credit, starting at rr_ptr.
  always_comb begin
    int              idx;
    logic [VC_W-1:0] idx_v;
    cred_found = 1'b0;
    grant_idx  = '0;
    idx        = 0;
    idx_v      = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx   = (int'(rr_ptr) + k) % NUM_VC;
      idx_v = VC_W'(idx);
      if (!cred_found && cred_nz[idx_v]) begin
        cred_found = 1'b1;
        grant_idx  = idx_v;
      end
    end
  end

  assign sel_ack  = (state == ST_IDLE) && !fifo_empty;
  assign sel_cred = (state == ST_IDLE) && fifo_empty && cred_found;
  assign sel_data = (state == ST_IDLE) && fifo_empty && !cred_found && (data_cnt != '0);

  for (genvar g = 0; g < NUM_VC; g++) begin : g_cred
    logic [CNT_W-1:0] cnt;

    assign cred_dec[g]     = sel_cred && (grant_idx == VC_W'(g));
    assign cred_nz[g]      = (cnt != '0);
    assign grtcred_full[g] = (cnt == CNT_MAX);

    // Saturating credit counter; a request coinciding with a grant cancels out.
    always_ff @(posedge CLK) begin
      if (!nRST) begin
        cnt <= '0;
      end else if (cred_dec[g] && !grtcred_write[g]) begin
        cnt <= cnt - CNT_W'(1);
      end else if (!cred_dec[g] && grtcred_write[g] && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign send_data_cnt_full = (data_cnt == CNT_MAX);

  // Saturating count of data packets waiting upstream.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      data_cnt <= '0;
    end else if (sel_data && !data_write) begin
      data_cnt <= data_cnt - CNT_W'(1);
    end else if (!sel_data && data_write && (data_cnt != CNT_MAX)) begin
      data_cnt <= data_cnt + CNT_W'(1);
    end
  end

  // Transmission FSM with registered start/get_data pulses and held selection.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state            <= ST_IDLE;
      rr_ptr           <= '0;
      start            <= 1'b0;
      get_data         <= 1'b0;
      comma_sel        <= IDLE_SEL;
      comma_header_out <= 8'h00;
    end else begin
      start    <= 1'b0;
      get_data <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_ack) begin
            state            <= ST_COMMA;
            start            <= 1'b1;
            comma_sel        <= ACK_SEL;
            comma_header_out <= fifo_head;
          end else if (sel_cred) begin
            state            <= ST_COMMA;
            start            <= 1'b1;
            comma_sel        <= GRTCRED_SEL;
            comma_header_out <= 8'(grant_idx);
            rr_ptr           <= (grant_idx == VC_W'(NUM_VC - 1)) ? '0 : grant_idx + VC_W'(1);
          end else if (sel_data) begin
            state            <= ST_DATA;
            start            <= 1'b1;
            get_data         <= 1'b1;
            comma_sel        <= START_PACKET_SEL;
            comma_header_out <= 8'h00;
          end
        end
        ST_COMMA: begin
          if (done) begin
            state            <= ST_IDLE;
            comma_sel        <= IDLE_SEL;
            comma_header_out <= 8'h00;
          end
        end
        ST_DATA: begin
          if (packet_done) begin
            state            <= ST_IDLE;
            comma_sel        <= IDLE_SEL;
            comma_header_out <= 8'h00;
          end
        end
        default: begin
          state            <= ST_IDLE;
          comma_sel        <= IDLE_SEL;
          comma_header_out <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_vc_arb_buffer.sv
// Directed, table-driven bench for multi_vc_arb_buffer (4 VCs, 2-bit counters).
module tb_multi_vc_arb_buffer;
  import phy_types_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ack_write;
  logic [7:0] rx_header;
  logic [3:0] grtcred_write;
  logic       data_write;
  logic       done;
  logic       packet_done;
  logic       start;
  comma_sel_t comma_sel;
  logic [7:0] comma_header_out;
  logic       get_data;
  logic       ack_cnt_full;
  logic [3:0] grtcred_full;
  logic       send_data_cnt_full;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       nrst;
    logic       aw;
    logic [7:0] rh;
    logic [3:0] gw;
    logic       dw;
    logic       dn;
    logic       pd;
    logic       e_start;
    comma_sel_t e_sel;
    logic [7:0] e_hdr;
    logic       e_gd;
    logic       e_busy;
    logic       e_af;
    logic [3:0] e_gf;
    logic       e_df;
  } vec_t;

  vec_t vecs[$];

  multi_vc_arb_buffer #(
    .NUM_VC    (4),
    .CNT_W     (2),
    .ACK_DEPTH (4)
  ) dut (
    .CLK                (clk),
    .nRST               (rst_n),
    .ack_write          (ack_write),
    .rx_header          (rx_header),
    .grtcred_write      (grtcred_write),
    .data_write         (data_write),
    .done               (done),
    .packet_done        (packet_done),
    .start              (start),
    .comma_sel          (comma_sel),
    .comma_header_out   (comma_header_out),
    .get_data           (get_data),
    .ack_cnt_full       (ack_cnt_full),
    .grtcred_full       (grtcred_full),
    .send_data_cnt_full (send_data_cnt_full),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic nrst, input logic aw, input logic [7:0] rh,
                              input logic [3:0] gw, input logic dw, input logic dn, input logic pd,
                              input logic es, input comma_sel_t esel, input logic [7:0] eh, input logic egd,
                              input logic eb, input logic eaf, input logic [3:0] egf, input logic edf);
    vec_t v;
    v.name = name; v.nrst = nrst; v.aw = aw; v.rh = rh; v.gw = gw; v.dw = dw; v.dn = dn; v.pd = pd;
    v.e_start = es; v.e_sel = esel; v.e_hdr = eh; v.e_gd = egd; v.e_busy = eb; v.e_af = eaf;
    v.e_gf = egf; v.e_df = edf;
    return v;
  endfunction

  task automatic check_field(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_output(input vec_t v);
    check_field({v.name, ".start"}, 8'(start), 8'(v.e_start));
    check_field({v.name, ".comma_sel"}, 8'(comma_sel), 8'(v.e_sel));
    check_field({v.name, ".header"}, comma_header_out, v.e_hdr);
    check_field({v.name, ".get_data"}, 8'(get_data), 8'(v.e_gd));
    check_field({v.name, ".busy"}, 8'(busy), 8'(v.e_busy));
    check_field({v.name, ".ack_full"}, 8'(ack_cnt_full), 8'(v.e_af));
    check_field({v.name, ".grt_full"}, 8'(grtcred_full), 8'(v.e_gf));
    check_field({v.name, ".data_full"}, 8'(send_data_cnt_full), 8'(v.e_df));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare just after it.
  task automatic apply_stimulus(input vec_t v);
    rst_n         = v.nrst;
    ack_write     = v.aw;
    rx_header     = v.rh;
    grtcred_write = v.gw;
    data_write    = v.dw;
    done          = v.dn;
    packet_done   = v.pd;
    @(posedge clk);
    #1;
    check_output(v);
  endtask

  initial begin
    int gd_count;
    rst_n = 1'b0; ack_write = 1'b0; rx_header = 8'h00; grtcred_write = 4'h0;
    data_write = 1'b0; done = 1'b0; packet_done = 1'b0;

    // Reset and done-in-IDLE
    vecs.push_back(mk("rst0",  0,0,8'h00,4'h0,0,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("rst1",  0,0,8'h00,4'h0,0,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("idle_done", 1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("idle_quiet",1,0,8'h00,4'h0,0,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    // Priority: ack > credit > data
    vecs.push_back(mk("pri_write", 1,1,8'hA5,4'h1,1,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("pri_ack",   1,0,8'h00,4'h0,0,0,0, 1,ACK_SEL,8'hA5,0,1,0,4'h0,0));
    vecs.push_back(mk("pri_ack_hold",1,0,8'h00,4'h0,0,0,0, 0,ACK_SEL,8'hA5,0,1,0,4'h0,0));
    vecs.push_back(mk("pri_ack_done",1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("pri_grt",   1,0,8'h00,4'h0,0,0,0, 1,GRTCRED_SEL,8'h00,0,1,0,4'h0,0));
    vecs.push_back(mk("pri_grt_done",1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("pri_data",  1,0,8'h00,4'h0,0,0,0, 1,START_PACKET_SEL,8'h00,1,1,0,4'h0,0));
    vecs.push_back(mk("data_ign_done",1,0,8'h00,4'h0,0,1,0, 0,START_PACKET_SEL,8'h00,0,1,0,4'h0,0));
    vecs.push_back(mk("data_pdone",1,0,8'h00,4'h0,0,0,1, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("pri_empty", 1,0,8'h00,4'h0,0,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    // Round-robin across four VCs, with VC0 re-requested after VC1 is granted
    vecs.push_back(mk("rr_rst",    0,0,8'h00,4'h0,0,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("rr_write",  1,0,8'h00,4'hF,0,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("rr_g0",     1,0,8'h00,4'h0,0,0,0, 1,GRTCRED_SEL,8'h00,0,1,0,4'h0,0));
    vecs.push_back(mk("rr_d0",     1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("rr_g1",     1,0,8'h00,4'h0,0,0,0, 1,GRTCRED_SEL,8'h01,0,1,0,4'h0,0));
    vecs.push_back(mk("rr_d1_vc0", 1,0,8'h00,4'h1,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("rr_g2",     1,0,8'h00,4'h0,0,0,0, 1,GRTCRED_SEL,8'h02,0,1,0,4'h0,0));
    vecs.push_back(mk("rr_d2",     1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("rr_g3",     1,0,8'h00,4'h0,0,0,0, 1,GRTCRED_SEL,8'h03,0,1,0,4'h0,0));
    vecs.push_back(mk("rr_d3",     1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("rr_g0_again",1,0,8'h00,4'h0,0,0,0, 1,GRTCRED_SEL,8'h00,0,1,0,4'h0,0));
    vecs.push_back(mk("rr_d0_again",1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("rr_empty",  1,0,8'h00,4'h0,0,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    // Ack FIFO fill while busy, drop at full, credit saturation on VC2
    vecs.push_back(mk("af_w11",    1,1,8'h11,4'h0,0,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("af_w22",    1,1,8'h22,4'h0,0,0,0, 1,ACK_SEL,8'h11,0,1,0,4'h0,0));
    vecs.push_back(mk("af_w33",    1,1,8'h33,4'h4,0,0,0, 0,ACK_SEL,8'h11,0,1,0,4'h0,0));
    vecs.push_back(mk("af_w44",    1,1,8'h44,4'h4,0,0,0, 0,ACK_SEL,8'h11,0,1,0,4'h0,0));
    vecs.push_back(mk("af_w55",    1,1,8'h55,4'h4,0,0,0, 0,ACK_SEL,8'h11,0,1,1,4'h4,0));
    vecs.push_back(mk("af_w66_drop",1,1,8'h66,4'h0,0,0,0, 0,ACK_SEL,8'h11,0,1,1,4'h4,0));
    vecs.push_back(mk("af_d11",    1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,1,4'h4,0));
    vecs.push_back(mk("af_s22",    1,0,8'h00,4'h0,0,0,0, 1,ACK_SEL,8'h22,0,1,0,4'h4,0));
    vecs.push_back(mk("af_d22",    1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h4,0));
    vecs.push_back(mk("af_s33",    1,0,8'h00,4'h0,0,0,0, 1,ACK_SEL,8'h33,0,1,0,4'h4,0));
    vecs.push_back(mk("af_d33",    1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h4,0));
    vecs.push_back(mk("af_s44",    1,0,8'h00,4'h0,0,0,0, 1,ACK_SEL,8'h44,0,1,0,4'h4,0));
    vecs.push_back(mk("af_d44",    1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h4,0));
    vecs.push_back(mk("af_s55",    1,0,8'h00,4'h0,0,0,0, 1,ACK_SEL,8'h55,0,1,0,4'h4,0));
    vecs.push_back(mk("af_d55",    1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h4,0));
    vecs.push_back(mk("cf_g2a",    1,0,8'h00,4'h0,0,0,0, 1,GRTCRED_SEL,8'h02,0,1,0,4'h0,0));
    vecs.push_back(mk("cf_d2a",    1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("cf_g2b",    1,0,8'h00,4'h0,0,0,0, 1,GRTCRED_SEL,8'h02,0,1,0,4'h0,0));
    vecs.push_back(mk("cf_d2b",    1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("cf_g2c",    1,0,8'h00,4'h0,0,0,0, 1,GRTCRED_SEL,8'h02,0,1,0,4'h0,0));
    vecs.push_back(mk("cf_d2c",    1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    vecs.push_back(mk("cf_empty",  1,0,8'h00,4'h0,0,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
    end

    // Data counter saturation: five writes while busy, counter stops at 3
    apply_stimulus(mk("sat_ack",  1,1,8'h3C,4'h0,0,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    apply_stimulus(mk("sat_dw1",  1,0,8'h00,4'h0,1,0,0, 1,ACK_SEL,8'h3C,0,1,0,4'h0,0));
    apply_stimulus(mk("sat_dw2",  1,0,8'h00,4'h0,1,0,0, 0,ACK_SEL,8'h3C,0,1,0,4'h0,0));
    apply_stimulus(mk("sat_dw3",  1,0,8'h00,4'h0,1,0,0, 0,ACK_SEL,8'h3C,0,1,0,4'h0,1));
    apply_stimulus(mk("sat_dw4",  1,0,8'h00,4'h0,1,0,0, 0,ACK_SEL,8'h3C,0,1,0,4'h0,1));
    apply_stimulus(mk("sat_dw5",  1,0,8'h00,4'h0,1,0,0, 0,ACK_SEL,8'h3C,0,1,0,4'h0,1));
    apply_stimulus(mk("sat_done", 1,0,8'h00,4'h0,0,1,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,1));

    // Drain: answer every data start with packet_done and count get_data pulses
    gd_count = 0;
    for (int c = 0; c < 20; c++) begin
      packet_done = (comma_sel == START_PACKET_SEL);
      done        = 1'b0;
      data_write  = 1'b0;
      @(posedge clk);
      #1;
      if (get_data) gd_count++;
    end
    packet_done = 1'b0;
    check_field("sat_get_data_pulses", 8'(gd_count), 8'd3);
    check_field("sat_busy_after", 8'(busy), 8'd0);
    check_field("sat_full_after", 8'(send_data_cnt_full), 8'd0);

    // Data write coinciding with the data pop keeps the count at one
    apply_stimulus(mk("sim_dw",    1,0,8'h00,4'h0,1,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    apply_stimulus(mk("sim_pop_dw",1,0,8'h00,4'h0,1,0,0, 1,START_PACKET_SEL,8'h00,1,1,0,4'h0,0));
    apply_stimulus(mk("sim_pd1",   1,0,8'h00,4'h0,0,0,1, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    apply_stimulus(mk("sim_again", 1,0,8'h00,4'h0,0,0,0, 1,START_PACKET_SEL,8'h00,1,1,0,4'h0,0));
    apply_stimulus(mk("sim_pd2",   1,0,8'h00,4'h0,0,0,1, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    apply_stimulus(mk("sim_empty", 1,0,8'h00,4'h0,0,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));

    // Reset one cycle after a data start abandons it and clears the counts
    apply_stimulus(mk("rmd_dw",    1,0,8'h00,4'h0,1,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    apply_stimulus(mk("rmd_start", 1,0,8'h00,4'h0,1,0,0, 1,START_PACKET_SEL,8'h00,1,1,0,4'h0,0));
    apply_stimulus(mk("rmd_rst",   0,0,8'h00,4'h0,0,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    apply_stimulus(mk("rmd_pdone", 1,0,8'h00,4'h0,0,0,1, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));
    apply_stimulus(mk("rmd_quiet", 1,0,8'h00,4'h0,0,0,0, 0,IDLE_SEL,8'h00,0,0,0,4'h0,0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
